// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-address generator.
// The optional return-address stack is enabled by defining PC_RAS_EN.
package pc_pkg;

  localparam int unsigned MAX_ADDR_W = 64;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_REDIR,
    SEL_RET,
    SEL_JUMP,
    SEL_HOLD,
    SEL_SEQ
  } sel_e;

  // Byte address to word address; callers truncate to their own width.
  function automatic logic [MAX_ADDR_W-3:0] byte_to_word(input logic [MAX_ADDR_W-1:0] byte_addr);
    return (MAX_ADDR_W-2)'(byte_addr >> 2);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// depth count saturates at DEPTH. DEPTH must be a power of two.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // ptr_q points at the next free slot; the top lives one below it.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(DEPTH)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[ptr_q] <= push_data_i;
    end
  end

  assign top_ptr = ptr_q - PTR_W'(1);
  assign top_o   = mem_q[top_ptr];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with boot/halt sequencing and next-PC priority select.
// Define PC_RAS_EN to build the return-address stack (pc_ras).
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0] TRAP_ADDR  = ADDR_W'('h80),
  parameter int unsigned       RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              trap,
  input  logic              redirect,
  input  logic [ADDR_W-3:0] redirect_addr,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-3:0] id_pc,
  input  logic [ADDR_W-3:0] jump_addr,
  output logic [ADDR_W-3:0] pc,
  output logic              fetch_valid,
  output logic              ras_miss
);

  localparam int unsigned   WW       = ADDR_W - 2;
  localparam logic [WW-1:0] RESET_PC = WW'(byte_to_word(MAX_ADDR_W'(RESET_ADDR)));
  localparam logic [WW-1:0] TRAP_PC  = WW'(byte_to_word(MAX_ADDR_W'(TRAP_ADDR)));

  state_e        state_q, state_d;
  sel_e          sel;
  logic [WW-1:0] pc_q, pc_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic          ras_miss_q, ras_miss_d;
  logic          ret_eff;
  logic [WW-1:0] ret_target;

  // State transition and next-PC source selection.
  always_comb begin
    state_d = state_q;
    sel     = SEL_HOLD;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req) state_d = ST_HALT;
        if (trap)                      sel = SEL_TRAP;
        else if (redirect)             sel = SEL_REDIR;
        else if (stall || halt_req)    sel = SEL_HOLD;
        else if (ret_eff)              sel = SEL_RET;
        else if (jump)                 sel = SEL_JUMP;
        else                           sel = SEL_SEQ;
      end
      ST_HALT: begin
        if (!halt_req) state_d = ST_RUN;
        if (trap)          sel = SEL_TRAP;
        else if (redirect) sel = SEL_REDIR;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    case (sel)
      SEL_TRAP:  pc_d = TRAP_PC;
      SEL_REDIR: pc_d = redirect_addr;
      SEL_RET:   pc_d = ret_target;
      SEL_JUMP:  pc_d = jump_addr;
      SEL_SEQ:   pc_d = pc_q + WW'(1);
      default:   pc_d = pc_q;
    endcase
    fetch_valid_d = (state_d == ST_RUN) && !stall;
  end

`ifdef PC_RAS_EN
  logic          call_eff;
  logic          ras_push;
  logic          ras_pop;
  logic          ras_empty;
  logic          ras_full;
  logic [WW-1:0] ras_top;
  logic          unused_ras;

  // A call and a return together resolve as the call.
  assign call_eff   = jump & call;
  assign ret_eff    = ret & ~call_eff;
  assign ras_push   = (sel == SEL_JUMP) && call_eff;
  assign ras_pop    = (sel == SEL_RET) && !ras_empty;
  assign ret_target = ras_empty ? jump_addr : ras_top;
  assign ras_miss_d = (sel == SEL_RET) && ras_empty;
  assign unused_ras = ras_full;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (WW)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (id_pc + WW'(1)),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .full_o      (ras_full)
  );
`else
  localparam int unsigned unused_ras_depth = RAS_DEPTH;
  logic unused_ras;

  assign ret_eff    = ret;
  assign ret_target = jump_addr;
  assign ras_miss_d = 1'b0;
  assign unused_ras = ^{call, id_pc};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      ras_miss_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      ras_miss_q    <= ras_miss_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign ras_miss    = ras_miss_q;

endmodule
